// File: rtl/vpi_snap_mailbox.sv
// Snapshot mailbox: captures {count, half_count} pairs into a small FIFO with sequence tags.
// Optional delta field is built only when VPI_SNAP_DELTA_EN is defined.
module vpi_snap_mailbox #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic [WIDTH-1:0] half_in,
  input  logic             snap_req,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_count,
  output logic [WIDTH-1:0] rd_half,
  output logic [WIDTH-1:0] rd_delta,
  output logic [7:0]       rd_seq,
  output logic             full,
  output logic             empty,
  output logic [7:0]       overrun_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr, r_rptr;
  logic [7:0]       r_seq;
  logic [WIDTH-1:0] r_mem_cnt  [DEPTH];
  logic [WIDTH-1:0] r_mem_half [DEPTH];
  logic [7:0]       r_mem_seq  [DEPTH];

  logic        w_pop, w_push, w_drop;
  logic [AW:0] w_wptr_nxt, w_rptr_nxt;

  assign w_pop      = rd_en && !empty;
  assign w_push     = snap_req && (!full || w_pop);
  assign w_drop     = snap_req && !w_push;
  assign w_wptr_nxt = r_wptr + {{AW{1'b0}}, w_push};
  assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_pop};

  // Flags are registered from the post-edge pointers so they match the new occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_seq       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      overrun_cnt <= '0;
      rd_valid    <= 1'b0;
      rd_count    <= '0;
      rd_half     <= '0;
      rd_seq      <= '0;
    end else begin
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      full     <= (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                  (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
      empty    <= (w_wptr_nxt == w_rptr_nxt);
      rd_valid <= w_pop;
      if (w_push) begin
        r_seq <= r_seq + 8'd1;
      end
      if (w_drop && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
      if (w_pop) begin
        rd_count <= r_mem_cnt[r_rptr[AW-1:0]];
        rd_half  <= r_mem_half[r_rptr[AW-1:0]];
        rd_seq   <= r_mem_seq[r_rptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_cnt[r_wptr[AW-1:0]]  <= cnt_in;
      r_mem_half[r_wptr[AW-1:0]] <= half_in;
      r_mem_seq[r_wptr[AW-1:0]]  <= r_seq;
    end
  end

`ifdef VPI_SNAP_DELTA_EN
  logic [WIDTH-1:0] r_last_count;
  logic [WIDTH-1:0] r_rd_delta;
  logic [WIDTH-1:0] r_mem_delta [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_count <= '0;
      r_rd_delta   <= '0;
    end else begin
      if (w_push) begin
        r_last_count <= cnt_in;
      end
      if (w_pop) begin
        r_rd_delta <= r_mem_delta[r_rptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_delta[r_wptr[AW-1:0]] <= cnt_in - r_last_count;
    end
  end

  assign rd_delta = r_rd_delta;
`else
  assign rd_delta = '0;
`endif

endmodule

// File: tb/tb_vpi_snap_mailbox.sv
// Randomised scoreboard bench for vpi_snap_mailbox against a queue-based reference model.
module tb_vpi_snap_mailbox;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] cnt_in = '0;
  logic [WIDTH-1:0] half_in = '0;
  logic             snap_req = 1'b0;
  logic             rd_en = 1'b0;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_count, rd_half, rd_delta;
  logic [7:0]       rd_seq;
  logic             full, empty;
  logic [7:0]       overrun_cnt;

  vpi_snap_mailbox #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .half_in(half_in),
    .snap_req(snap_req), .rd_en(rd_en), .rd_valid(rd_valid),
    .rd_count(rd_count), .rd_half(rd_half), .rd_delta(rd_delta),
    .rd_seq(rd_seq), .full(full), .empty(empty), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] delta;
    logic [7:0]       seq;
  } ent_t;

  typedef struct {
    ent_t        e;
    int unsigned due;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];

  logic [WIDTH-1:0] m_last;
  logic [7:0]       m_seq;
  logic [7:0]       m_ovr;
  ent_t             m_hold;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // One clock of stimulus; the model decides pop/push from its own occupancy.
  task automatic step(input logic s, input logic r, input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] h);
    bit   pop, push;
    ent_t e;
    exp_t x;
    @(negedge clk);
    snap_req = s;
    rd_en    = r;
    cnt_in   = c;
    half_in  = h;
    pop  = r && (mq.size() != 0);
    push = s && ((mq.size() < DEPTH) || pop);
    if (pop) begin
      x.e   = mq.pop_front();
      x.due = cyc + 1;
      exp_q.push_back(x);
    end
    if (push) begin
      e.cnt  = c;
      e.half = h;
`ifdef VPI_SNAP_DELTA_EN
      e.delta = c - m_last;
`else
      e.delta = '0;
`endif
      e.seq  = m_seq;
      m_last = c;
      m_seq  = m_seq + 8'd1;
      mq.push_back(e);
    end else if (s && (m_ovr != 8'hFF)) begin
      m_ovr = m_ovr + 8'd1;
    end
    @(posedge clk);
    #1;
    chk("full", {63'd0, full}, {63'd0, mq.size() == DEPTH});
    chk("empty", {63'd0, empty}, {63'd0, mq.size() == 0});
    chk("overrun_cnt", {56'd0, overrun_cnt}, {56'd0, m_ovr});
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, $urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    snap_req = 1'b0;
    rd_en    = 1'b0;
    #1;
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_rd_count", {32'd0, rd_count}, 64'd0);
    chk("rst_rd_half", {32'd0, rd_half}, 64'd0);
    chk("rst_rd_delta", {32'd0, rd_delta}, 64'd0);
    chk("rst_rd_seq", {56'd0, rd_seq}, 64'd0);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_overrun", {56'd0, overrun_cnt}, 64'd0);
    mq.delete();
    exp_q.delete();
    m_last = '0;
    m_seq  = '0;
    m_ovr  = '0;
    m_hold = '{default: '0};
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    m_last = '0;
    m_seq  = '0;
    m_ovr  = '0;
    m_hold = '{default: '0};

    fork
      begin : monitor
        bit   due;
        exp_t x;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            due = (exp_q.size() != 0) && (exp_q[0].due == cyc);
            chk("rd_valid", {63'd0, rd_valid}, {63'd0, due});
            if (due) begin
              x      = exp_q.pop_front();
              m_hold = x.e;
            end
            chk("rd_count", {32'd0, rd_count}, {32'd0, m_hold.cnt});
            chk("rd_half", {32'd0, rd_half}, {32'd0, m_hold.half});
            chk("rd_delta", {32'd0, rd_delta}, {32'd0, m_hold.delta});
            chk("rd_seq", {56'd0, rd_seq}, {56'd0, m_hold.seq});
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    do_reset();

    // Single capture and pop.
    step(1'b1, 1'b0, 32'd10, 32'd4);
    step(1'b0, 1'b1, $urandom, $urandom);
    idle(2);

    // Two captures, delta between them.
    do_reset();
    step(1'b1, 1'b0, 32'd100, 32'd50);
    step(1'b1, 1'b0, 32'd130, 32'd65);
    step(1'b0, 1'b1, $urandom, $urandom);
    step(1'b0, 1'b1, $urandom, $urandom);
    idle(2);

    // Fill, overrun, simultaneous push/pop while full, drain.
    do_reset();
    for (int unsigned i = 0; i < DEPTH + 3; i++) step(1'b1, 1'b0, 32'd200 + i, 32'd7 * i);
    chk("overrun_eq3", {56'd0, overrun_cnt}, 64'd3);
    chk("full_after_fill", {63'd0, full}, 64'd1);
    step(1'b1, 1'b1, 32'd500, 32'd250);
    chk("full_after_swap", {63'd0, full}, 64'd1);
    for (int unsigned i = 0; i < DEPTH; i++) step(1'b0, 1'b1, $urandom, $urandom);
    step(1'b1, 1'b1, 32'd600, 32'd300);
    step(1'b0, 1'b1, $urandom, $urandom);
    idle(2);

    // Capture/pop pairs across seq wrap and counter wrap.
    do_reset();
    for (int unsigned i = 0; i < 300; i++) begin
      logic [WIDTH-1:0] c;
      c = (i == 150) ? 32'hFFFF_FFFE : (i == 151) ? 32'd4 : $urandom;
      step(1'b1, 1'b0, c, $urandom);
      step(1'b0, 1'b1, $urandom, $urandom);
    end
    idle(2);

    // Random mixed traffic.
    for (int unsigned i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    idle(3);

    // Overrun saturation.
    do_reset();
    for (int unsigned i = 0; i < DEPTH + 260; i++) step(1'b1, 1'b0, $urandom, $urandom);
    chk("overrun_sat", {56'd0, overrun_cnt}, 64'd255);

    // Reset while a pulse is out and entries are queued.
    do_reset();
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd40 + i, 32'd20 + i);
    step(1'b0, 1'b1, $urandom, $urandom);
    do_reset();
    step(1'b0, 1'b1, $urandom, $urandom);
    idle(2);
    chk("rd_valid_after_reset", {63'd0, rd_valid}, 64'd0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vpi_snap_mailbox.md
# vpi_snap_mailbox

Snapshot mailbox that sits directly downstream of the public counter pair (`count`, `half_count`) in the VPI variable test design. On a one-cycle request it captures a coherent copy of both counters into a small FIFO, tagged with a sequence number and the count delta since the previous snapshot. A VPI or testbench reader drains the FIFO through a registered read port, so it never samples the live counters mid-update.

## Interface
- `WIDTH`, 32: width of the counter inputs and of the snapshot count, half and delta fields.
- `DEPTH`, 4: FIFO entries; must be a power of 2, minimum 2.
- `clk` in 1: single clock; all state changes on its posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cnt_in` in WIDTH: live `count` value.
- `half_in` in WIDTH: live `half_count` value.
- `snap_req` in 1: capture request, sampled each posedge.
- `rd_en` in 1: pop request, sampled each posedge.
- `rd_valid` out 1: one-cycle pulse; the `rd_*` data fields below are valid.
- `rd_count` out WIDTH: captured count.
- `rd_half` out WIDTH: captured half count.
- `rd_delta` out WIDTH: captured count minus the previous accepted capture's count.
- `rd_seq` out 8: sequence number of the entry.
- `full` out 1: FIFO holds DEPTH entries.
- `empty` out 1: FIFO holds 0 entries.
- `overrun_cnt` out 8: number of dropped requests; saturates.

## Operation
- Storage is a circular FIFO with DEPTH entries. Each entry holds {count, half, delta, seq}. The block has write and read pointers of log2(DEPTH)+1 bits.
- Push accept condition: `snap_req && (!full || pop_accepted)`.
  - The entry stores `cnt_in`, `half_in`, `cnt_in - last_count` (mod 2^WIDTH) and `seq_ctr`.
  - Then `last_count <= cnt_in` and `seq_ctr <= seq_ctr + 1`, wrapping 255 to 0.
- Pop accept condition: `rd_en && !empty`.
  - The head entry loads into the `rd_*` registers.
  - `rd_valid` goes to 1 for the next cycle only.
- `rd_en` while empty is ignored and `rd_valid` stays 0.
- The `rd_*` data registers hold their last value when `rd_valid` is 0.
- When full, pop and push in the same cycle are both accepted and occupancy is unchanged.
- A push attempted while full with no pop is dropped:
  - `overrun_cnt` increments and saturates at 255.
  - `seq_ctr` and `last_count` do not change.
- The first accepted snapshot after reset has delta = `cnt_in` (`last_count` resets to 0).
- Pointers wrap modulo 2·DEPTH.
  - `full` when the MSBs differ and the low bits are equal.
  - `empty` when the pointers are equal.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - `rd_valid`, `rd_count`, `rd_half`, `rd_delta`, `rd_seq` = 0.
  - `full` = 0, `empty` = 1, `overrun_cnt` = 0.
  - Internal `seq_ctr`, `last_count` and both pointers = 0.
- Reset asserted mid-operation discards all entries. A `rd_valid` pulse in flight is cleared.
- Push on edge N: `empty` deasserts after edge N, and the entry is poppable at edge N+1.
- Pop on edge M: `rd_valid` and data are valid in the cycle after edge M.
- Minimum latency from `snap_req` to `rd_valid` is 2 edges.
- `full` and `empty` are registered and reflect the state after the current edge's push/pop.

## Configuration
- `VPI_SNAP_DELTA_EN`:
  - Defined: delta computation, the `last_count` register and the delta FIFO field are present, as described above.
  - Undefined: `rd_delta` is constant 0, and `last_count` and the delta storage are not built. All other behaviour is identical.

## Test plan
- Reset, then `snap_req` with `cnt_in`=10, `half_in`=4, then `rd_en` next cycle -> `rd_valid`=1 with count 10, half 4, delta 10, seq 0; `empty`=1 afterwards.
- Two captures at `cnt_in`=100 then 130, then pop both -> deltas 100 then 30, seq 0 then 1. Without `VPI_SNAP_DELTA_EN`, both deltas are 0.
- Fill DEPTH=4 entries, then 3 more requests with no pop -> `full`=1, `overrun_cnt`=3; popped seqs are 0..3 and the next accepted capture gets seq 4.
- While full, assert `snap_req` and `rd_en` together with `cnt_in`=500 -> `full` stays 1 and `overrun_cnt` is unchanged; the fifth pop returns count 500.
- 300 capture/pop pairs -> seq wraps 255 to 0; `cnt_in` stepping from 2^32-2 to 4 gives delta 6. Separately, 260 drops leave `overrun_cnt`=255.
- `rst_n` low during a cycle with `rd_valid`=1 and 2 entries queued -> all outputs return to their reset values immediately; a following `rd_en` produces no `rd_valid`.
